// File: rtl/diff2d_pkg.sv
// ============================================================
// diff2d_pkg : shared state encoding and mode constants
// Rev 1.0
// ============================================================
`default_nettype none

package diff2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic MODE_BWD = 1'b0;
  localparam logic MODE_FWD = 1'b1;

endpackage

`default_nettype wire

// File: rtl/line_delay.sv
// ============================================================
// line_delay : one-row shift register with newest/oldest/second-oldest taps
// Rev 1.0
// ============================================================
`default_nettype none

module line_delay #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] newest,
  output logic [WIDTH-1:0] oldest,
  output logic [WIDTH-1:0] second_oldest
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: boundary rules in the consumer mask any stale contents.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign newest        = mem[0];
  assign oldest        = mem[DEPTH-1];
  assign second_oldest = mem[DEPTH-2];

endmodule

`default_nettype wire

// File: rtl/diff2d_stream.sv
// ============================================================
// diff2d_stream : streaming 2-D backward/forward difference (Dx, Dy)
// Rev 1.0
// ============================================================
`default_nettype none

module diff2d_stream
  import diff2d_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int COLS  = 64,
  parameter int ROWS  = 64
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [WIDTH:0]     o_datax,
  output logic [WIDTH:0]     o_datay,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic               o_busy
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic signed [WIDTH:0] ZERO = '0;

  state_t state, state_nxt;
  logic            mode;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [WIDTH-1:0] tap_new, tap_old, tap_old2, shift_din;
  logic            shift_en, line_clr, emit, last_nxt;
  logic            accept, consume, frame_end, flush_step, col_wrap, frame_last_px;
  logic signed [WIDTH:0] px, p_new, p_old, p_old2, dx_nxt, dy_nxt;

  line_delay #(.WIDTH(WIDTH), .DEPTH(COLS)) u_line (
    .clk          (i_clk),
    .en           (shift_en),
    .clr          (line_clr),
    .din          (shift_din),
    .newest       (tap_new),
    .oldest       (tap_old),
    .second_oldest(tap_old2)
  );

  assign px     = {i_data[WIDTH-1], i_data};
  assign p_new  = {tap_new[WIDTH-1], tap_new};
  assign p_old  = {tap_old[WIDTH-1], tap_old};
  assign p_old2 = {tap_old2[WIDTH-1], tap_old2};

  assign o_ready       = (state == RUN) && (!o_valid || i_ready);
  assign o_busy        = (state != IDLE);
  assign accept        = i_valid && o_ready;
  assign consume       = o_valid && i_ready;
  assign frame_end     = consume && o_last;
  assign col_wrap      = (col == COL_LAST);
  assign frame_last_px = col_wrap && (row == ROW_LAST);
  // Forward frames emit their final row here; backward frames only wait in FLUSH for o_last to drain.
  assign flush_step    = (state == FLUSH) && (mode == MODE_FWD) &&
                         (!o_valid || i_ready) && !(o_valid && o_last);

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    last_nxt  = 1'b0;
    dx_nxt    = ZERO;
    dy_nxt    = ZERO;
    shift_en  = 1'b0;
    shift_din = i_data;
    line_clr  = 1'b0;
    case (state)
      IDLE: if (i_start) state_nxt = RUN;
      RUN: begin
        if (accept) begin
          shift_en = 1'b1;
          if (mode == MODE_BWD) begin
            emit     = 1'b1;
            dx_nxt   = (col == '0) ? ZERO : px - p_new;
            dy_nxt   = (row == '0) ? ZERO : px - p_old;
            last_nxt = frame_last_px;
          end else begin
            emit   = (row != '0);
            dx_nxt = col_wrap ? ZERO : p_old2 - p_old;
            dy_nxt = px - p_old;
          end
          if (frame_last_px) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_step) begin
          emit      = 1'b1;
          shift_en  = 1'b1;
          shift_din = '0;
          dx_nxt    = col_wrap ? ZERO : p_old2 - p_old;
          last_nxt  = col_wrap;
        end else if (frame_end) begin
          line_clr  = 1'b1;
          state_nxt = i_start ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      mode    <= MODE_BWD;
      col     <= '0;
      row     <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_datax <= '0;
      o_datay <= '0;
    end else begin
      state <= state_nxt;
      if (i_start && (state == IDLE || frame_end)) mode <= i_mode;
      if (frame_end) begin
        col <= '0;
        row <= '0;
      end else if (accept || flush_step) begin
        col <= col_wrap ? '0 : col + 1'b1;
        if (accept && col_wrap) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end
      if (emit) begin
        o_valid <= 1'b1;
        o_datax <= dx_nxt;
        o_datay <= dy_nxt;
        o_last  <= last_nxt;
      end else if (consume) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_diff2d_stream.sv
// ============================================================
// tb_diff2d_stream : directed self-checking bench for diff2d_stream
// Rev 1.0
// ============================================================
`default_nettype none

module tb_diff2d_stream;

  localparam int WIDTH = 8;
  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int NPIX  = ROWS * COLS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic ready, valid, last, busy;
  logic [WIDTH:0] dx, dy;

  int checks = 0;
  int failures = 0;
  int qx[$], qy[$], ql[$], qr[$];
  logic prev_hold = 1'b0;
  logic [WIDTH:0] prev_dx = '0, prev_dy = '0;

  always #5 clk = ~clk;

  diff2d_stream #(.WIDTH(WIDTH), .COLS(COLS), .ROWS(ROWS)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_start  (start),
    .i_mode   (mode),
    .i_data   (in_data),
    .i_valid  (in_valid),
    .o_ready  (ready),
    .o_datax  (dx),
    .o_datay  (dy),
    .o_valid  (valid),
    .i_ready  (out_ready),
    .o_last   (last),
    .o_busy   (busy)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Capture consumed outputs and watch stability while stalled.
  always @(negedge clk) begin
    if (rst_n && valid && out_ready) begin
      qx.push_back(int'($signed(dx)));
      qy.push_back(int'($signed(dy)));
      ql.push_back(int'(last));
      qr.push_back(int'(ready));
    end
    if (rst_n && prev_hold) begin
      check("hold_valid", valid, 1);
      check("hold_dx", $signed(dx), $signed(prev_dx));
      check("hold_dy", $signed(dy), $signed(prev_dy));
    end
    if (rst_n && valid && !out_ready) check("stall_ready", ready, 0);
    prev_hold = rst_n && valid && !out_ready;
    prev_dx   = dx;
    prev_dy   = dy;
  end

  function automatic int pattern(input int sel, input int idx);
    if (sel == 0) return 10 * (idx / COLS) + (idx % COLS);
    case (idx)
      0:       return 127;
      1:       return -128;
      4:       return -128;
      default: return 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    qx.delete(); qy.delete(); ql.delete(); qr.delete();
  endtask

  task automatic start_frame(input logic m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    mode  = ~m;
  endtask

  task automatic send_pixel(input int v);
    int n = 0;
    in_valid = 1'b1;
    in_data  = v[WIDTH-1:0];
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_last"},  last, 0);
    check({tag, "_dx"},    dx, 0);
    check({tag, "_dy"},    dy, 0);
  endtask

  // Expected values hand-derived for p(r,c)=10r+c.
  task automatic check_frame(input string name, input logic m);
    check({name, "_count"}, qx.size(), NPIX);
    for (int k = 0; k < NPIX && k < qx.size(); k++) begin
      int r = k / COLS;
      int c = k % COLS;
      int ex = m ? ((c == COLS-1) ? 0 : 1)  : ((c == 0) ? 0 : 1);
      int ey = m ? ((r == ROWS-1) ? 0 : 10) : ((r == 0) ? 0 : 10);
      check($sformatf("%s_dx%0d", name, k), qx[k], ex);
      check($sformatf("%s_dy%0d", name, k), qy[k], ey);
      check($sformatf("%s_last%0d", name, k), ql[k], (k == NPIX-1) ? 1 : 0);
      if (m && k >= NPIX - COLS) check($sformatf("%s_flush_ready%0d", name, k), qr[k], 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Backward frame with 1-cycle latency check
    clear_q();
    start_frame(1'b0);
    send_pixel(pattern(0, 0));
    check("bwd_latency_valid", valid, 1);
    for (int i = 1; i < NPIX; i++) send_pixel(pattern(0, i));
    wait_idle("bwd_idle");
    check_frame("bwd", 1'b0);

    // Forward frame; start pulses in RUN and FLUSH must be ignored
    clear_q();
    start_frame(1'b1);
    for (int i = 0; i < COLS; i++) send_pixel(pattern(0, i));
    check("fwd_row0_quiet", valid, 0);
    send_pixel(pattern(0, COLS));
    check("fwd_first_valid", valid, 1);
    check("fwd_first_dx", $signed(dx), 1);
    check("fwd_first_dy", $signed(dy), 10);
    start = 1'b1;
    send_pixel(pattern(0, COLS + 1));
    start = 1'b0;
    for (int i = COLS + 2; i < NPIX; i++) send_pixel(pattern(0, i));
    check("fwd_in_flush_busy", busy, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("fwd_idle");
    repeat (3) tick();
    check("fwd_start_ignored", busy, 0);
    check_frame("fwd", 1'b1);

    // Overflow: exact 9-bit results
    clear_q();
    start_frame(1'b0);
    for (int i = 0; i < NPIX; i++) send_pixel(pattern(1, i));
    wait_idle("ovf_idle");
    check("ovf_count", qx.size(), NPIX);
    if (qx.size() >= 6) begin
      check("ovf_dx1", qx[1], -255);
      check("ovf_dy1", qy[1], 0);
      check("ovf_dx4", qx[4], 0);
      check("ovf_dy4", qy[4], -255);
      check("ovf_dx5", qx[5], 128);
      check("ovf_dy5", qy[5], 128);
    end

    // Backpressure: 5-cycle stall mid-frame
    clear_q();
    start_frame(1'b0);
    fork
      for (int i = 0; i < NPIX; i++) send_pixel(pattern(0, i));
      begin
        repeat (5) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
      end
    join
    wait_idle("bp_idle");
    check_frame("bp", 1'b0);

    // Reset mid-frame, then a clean frame
    clear_q();
    start_frame(1'b0);
    for (int i = 0; i < 7; i++) send_pixel(pattern(0, i));
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    clear_q();
    start_frame(1'b0);
    for (int i = 0; i < NPIX; i++) send_pixel(pattern(0, i));
    wait_idle("rst_idle");
    check_frame("rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/diff2d_stream.md
DIFF2D_STREAM -- requirements
Module: diff2d_stream

Interface
REQ-001 Parameter WIDTH, default 32: signed input pixel width in bits.
REQ-002 Parameter COLS, default 64: pixels per row (at least 2).
REQ-003 Parameter ROWS, default 64: rows per frame (at least 2).
REQ-004 Port i_clk  input  1: single clock; all state changes on the rising edge.
REQ-005 Port i_reset_n  input  1: asynchronous, active-low reset.
REQ-006 Port i_start  input  1: pulse that arms one frame and latches i_mode.
REQ-007 Port i_mode  input  1: 0 = backward difference, 1 = forward difference.
REQ-008 Port i_data  input  WIDTH: signed pixel, raster order (row-major, column 0 first).
REQ-009 Port i_valid  input  1: i_data is valid.
REQ-010 Port o_ready  output  1: block accepts i_data this cycle.
REQ-011 Port o_datax  output  WIDTH+1: signed horizontal difference Dx.
REQ-012 Port o_datay  output  WIDTH+1: signed vertical difference Dy.
REQ-013 Port o_valid  output  1: o_datax and o_datay are valid.
REQ-014 Port i_ready  input  1: downstream accepts the output this cycle.
REQ-015 Port o_last  output  1: marks the output for pixel (ROWS-1, COLS-1).
REQ-016 Port o_busy  output  1: high in every state other than IDLE.

Function
REQ-017 The block SHALL implement three states: IDLE, RUN and FLUSH.
REQ-018 IDLE->RUN: on i_start, with i_mode latched; i_start is ignored outside IDLE.
REQ-019 Input acceptance: a pixel is accepted when i_valid && o_ready.
REQ-020 o_ready SHALL equal (state==RUN) && (!o_valid || i_ready).
REQ-021 Output consumption: an output is consumed when o_valid && i_ready.
REQ-022 Output stability: o_datax, o_datay and o_last SHALL hold stable while o_valid && !i_ready.
REQ-023 Counters: col and row SHALL count accepted pixels; col wraps at COLS-1 and row increments on that wrap.
REQ-024 Line delay: the block SHALL hold the last COLS accepted pixels in a delay line. Newest entry = left neighbour p(r,c-1); oldest entry = above neighbour p(r-1,c); second-oldest entry = p(r-1,c+1).
REQ-025 Backward mode: on accepting p(r,c), the block SHALL register, one cycle later, Dx = p(r,c)-p(r,c-1) (0 when c=0) and Dy = p(r,c)-p(r-1,c) (0 when r=0).
REQ-026 Forward mode, row 0: accepting row 0 SHALL produce no output.
REQ-027 Forward mode, rows 1..ROWS-1: accepting p(r,c) SHALL produce the output for (r-1,c). Dx = p(r-1,c+1)-p(r-1,c) (0 when c=COLS-1); Dy = p(r,c)-p(r-1,c).
REQ-028 Forward FLUSH: after the last pixel of a forward frame is accepted, the block SHALL enter FLUSH and emit COLS outputs for row ROWS-1. In these outputs Dy=0 and Dx follows REQ-027; zeros are shifted into the delay line; each output advances only on consumption or on an empty output register.
REQ-029 Arithmetic: operands SHALL be sign-extended to WIDTH+1 before subtraction; results are exact, with no saturation or wrap.
REQ-030 o_last SHALL be high only with the output for pixel (ROWS-1, COLS-1), in both modes.
REQ-031 Frame end: after the o_last output is consumed, the block SHALL return to IDLE. Counters and delay line are cleared, and a new i_start may arrive in the same cycle as the consumption.
REQ-032 Every frame SHALL emit exactly ROWS*COLS outputs.

Reset
REQ-033 Asserting reset SHALL force the following, at any time and including mid-frame: state=IDLE, o_valid=0, o_ready=0, o_last=0, o_busy=0, o_datax=0, o_datay=0, counters=0, latched mode=0.
REQ-034 The delay-line contents need not be reset; correctness SHALL depend only on the row/col boundary rules.
REQ-035 Reset deassertion SHALL be accepted synchronously to i_clk; the first i_start is honoured one cycle after deassertion.

Structure
REQ-036 Shared package diff2d_pkg SHALL hold the state enum (IDLE/RUN/FLUSH) and the mode constants MODE_BWD=0 and MODE_FWD=1.
REQ-037 The delay line SHALL be a sub-module line_delay, with parameters WIDTH and DEPTH=COLS, a shift-enable input, and taps for the newest, oldest and second-oldest entries.

Verification
REQ-038 Backward mode: COLS=4, ROWS=3, WIDTH=8, p(r,c)=10r+c, i_ready=1 -> 12 outputs. Dx=1 except c=0 gives 0; Dy=10 except r=0 gives 0; o_last on output 12; latency 1 cycle.
REQ-039 Forward mode, same frame -> first output follows acceptance of p(1,0); 12 outputs total. Dx=1 except c=3 gives 0; Dy=10 except r=2 gives 0; last 4 outputs during FLUSH with o_ready=0.
REQ-040 Overflow, WIDTH=8, backward mode: p(0,0)=127 then p(0,1)=-128 -> Dx=-255 (9-bit signed). Next row with p(1,0)=-128 under 127 -> Dy=-255.
REQ-041 Backpressure: i_ready low for 5 cycles mid-frame -> o_data and o_valid held stable, o_ready=0, no pixel lost or duplicated; output sequence identical to REQ-038.
REQ-042 Reset mid-frame: assert reset after pixel 7 -> all outputs 0 in the same cycle. A new frame after i_start reproduces REQ-038 exactly, with no stale Dy in row 0.
REQ-043 i_start pulses during RUN and FLUSH -> ignored; mode unchanged; frame output count still 12.
